seconds_counter: RTL
====================

Name: seconds_counter

Overview:
Upstream neighbour of the minutes counter in the clock datapath. Divides the system clock down to a 1 Hz tick and counts seconds 0..59. Emits a single-cycle sec_rollover pulse that drives the minutes counter's increment input. Provides start/stop control and a validated seconds-preset interface.

Parameters:
CLK_HZ, 50_000_000, system clock cycles per second (prescaler terminal = CLK_HZ-1); legal range >= 1.
PRESCALE_W, $clog2(CLK_HZ) (minimum 1), prescaler counter width (derived; not overridden).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level/pulse; enter RUNNING
stop  input  1  level/pulse; enter STOPPED
set_valid  input  1  preset request
set_value  input  6  preset seconds value
set_ready  output  1  high when a preset can be accepted (STOPPED only)
set_err  output  1  one-cycle pulse: accepted preset was out of range
seconds  output  6  current seconds, 0..59
sec_tick  output  1  one-cycle pulse on every seconds increment
sec_rollover  output  1  one-cycle pulse when seconds wraps 59->0; feeds minutes counter
running  output  1  high in RUNNING

Behaviour:
- Reset (async assert, sync-safe deassert by system): seconds=0, prescaler=0, state=STOPPED, sec_tick=0, sec_rollover=0, set_err=0, running=0.
- FSM states are STOPPED and RUNNING; running = (state==RUNNING); set_ready = (state==STOPPED).
- STOPPED -> RUNNING on start & !stop. RUNNING -> STOPPED on stop. If start and stop are both high, stop wins.
- Prescaler behaviour:
  - In RUNNING, the prescaler increments every cycle 0..CLK_HZ-1.
  - At terminal (CLK_HZ-1), the prescaler returns to 0 and seconds advances on the same edge.
  - In STOPPED, the prescaler holds its value; a later start resumes mid-second and does not clear it.
- Seconds advance: seconds+1, or 0 if seconds==59.
- sec_tick and sec_rollover are registered:
  - They are high for exactly one cycle, in the cycle where seconds first shows the new value.
  - sec_rollover is high only when the new value is 0 after a wrap.
  - Minutes therefore update one clk after seconds reads 0.
- Stop sampled on a terminal edge: the prescaler wrap and seconds advance still occur on that edge (the current state is RUNNING), then the FSM is STOPPED.
- Preset handshake:
  - A preset is accepted on set_valid & set_ready at the edge.
  - If set_value <= 59: seconds <= set_value, prescaler <= 0; no sec_tick or sec_rollover.
  - If set_value > 59: seconds and prescaler are unchanged, and set_err pulses for one cycle.
  - In RUNNING, set_valid is ignored and nothing is consumed; the source holds set_valid until set_ready.
  - Preset and start in the same cycle: the preset applies, and the FSM enters RUNNING with prescaler=0.
- CLK_HZ=1: sec_tick fires every RUNNING cycle.
- Async reset mid-count: all state returns to reset values immediately, and no pulse is emitted on deassertion.
- All arithmetic is unsigned. The prescaler compare is against CLK_HZ-1, truncated to PRESCALE_W.

Decomposition:
- Shared package clock_pkg holds:
  - SEC_MAX=59
  - TIME_W=6
  - the run-state enum {STOPPED, RUNNING}, reused later by the minutes and hours stages.
- One natural sub-module, tick_prescaler, with parameter CLK_HZ, inputs clk/rst_n/en/clr and output terminal pulse. It is reused for other timebases.

Test Plan (CLK_HZ=4):
- Reset then start held one cycle -> running=1 next cycle; sec_tick pulses every 4 cycles; seconds goes 0,1,2...
- Preset 58 in STOPPED, then start -> after 4 cycles seconds=59; after 8 cycles seconds=0 with sec_tick=1 and sec_rollover=1 for exactly one cycle.
- Preset 60 -> set_err pulses one cycle; seconds unchanged at its prior value (e.g. 0).
- Start, then after 2 cycles stop for 5 cycles, then start -> the next tick arrives 2 RUNNING cycles after resume (prescaler held at 2).
- start and stop high together from STOPPED -> stays STOPPED; set_valid in RUNNING with value 10 -> set_ready=0, seconds unaffected.
- Assert rst_n=0 mid-second at seconds=59 -> outputs are 0 immediately; no sec_rollover after release.

Source files
------------

// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Package     : clock_pkg
// Description : Shared constants, run-state enum and helpers for the clock
//               datapath stages (seconds / minutes / hours).
// Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

  localparam int SEC_MAX = 59;
  localparam int TIME_W  = 6;

  typedef enum logic [0:0] {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } run_state_e;

  // Modulo-(max+1) increment used by every time-of-day stage
  function automatic logic [TIME_W-1:0] wrap_inc(input logic [TIME_W-1:0] v,
                                                 input logic [TIME_W-1:0] max);
    return (v == max) ? '0 : v + TIME_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Free-running divide-by-CLK_HZ counter. terminal is high in the
//               cycle the counter sits at CLK_HZ-1 while enabled; the counter
//               wraps to 0 on that same edge. Holds its value when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int PRESCALE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic terminal
);

  // Terminal count truncated to the counter width
  localparam logic [PRESCALE_W-1:0] C_TERM = PRESCALE_W'(CLK_HZ - 1);

  logic [PRESCALE_W-1:0] count_q;
  logic [PRESCALE_W-1:0] count_d;

  // Next count: clear wins, otherwise advance and wrap at terminal while enabled
  always_comb begin
    terminal = en && (count_q == C_TERM);
    count_d  = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = terminal ? '0 : count_q + PRESCALE_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seconds_counter.sv
`default_nettype none
// ============================================================================
// Module      : seconds_counter
// Description : Divides the system clock to 1 Hz and counts seconds 0..59 with
//               start/stop control, a validated preset handshake and
//               registered tick / rollover pulses for the minutes stage.
// Revision    : 1.0 - initial release
// ============================================================================
module seconds_counter
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              set_valid,
  input  logic [TIME_W-1:0] set_value,
  output logic              set_ready,
  output logic              set_err,
  output logic [TIME_W-1:0] seconds,
  output logic              sec_tick,
  output logic              sec_rollover,
  output logic              running
);

  localparam int PRESCALE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TIME_W-1:0] C_SEC_MAX = TIME_W'(SEC_MAX);

  run_state_e        state_q, state_d;
  logic [TIME_W-1:0] seconds_q, seconds_d;
  logic              sec_tick_q, sec_tick_d;
  logic              sec_rollover_q, sec_rollover_d;
  logic              set_err_q, set_err_d;

  logic              presc_en;
  logic              presc_term;
  logic              preset_take;
  logic              preset_ok;

  // Preset is only consumed while stopped; in-range values also realign the prescaler
  always_comb begin
    preset_take = set_valid && (state_q == STOPPED);
    preset_ok   = preset_take && (set_value <= C_SEC_MAX);
    presc_en    = (state_q == RUNNING);
  end

  tick_prescaler #(
    .CLK_HZ     (CLK_HZ),
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (presc_en),
    .clr      (preset_ok),
    .terminal (presc_term)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STOPPED;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: stop has priority over start
  always_comb begin
    state_d = state_q;
    case (state_q)
      STOPPED: if (start && !stop) state_d = RUNNING;
      RUNNING: if (stop)           state_d = STOPPED;
      default:                     state_d = STOPPED;
    endcase
  end

  // FSM outputs
  always_comb begin
    running   = (state_q == RUNNING);
    set_ready = (state_q == STOPPED);
  end

  // Seconds datapath and pulse generation; terminal and preset are mutually exclusive
  always_comb begin
    seconds_d      = seconds_q;
    sec_tick_d     = 1'b0;
    sec_rollover_d = 1'b0;
    set_err_d      = preset_take && !preset_ok;
    if (presc_term) begin
      seconds_d      = wrap_inc(seconds_q, C_SEC_MAX);
      sec_tick_d     = 1'b1;
      sec_rollover_d = (seconds_q == C_SEC_MAX);
    end else if (preset_ok) begin
      seconds_d = set_value;
    end
  end

  // Seconds and pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seconds_q      <= '0;
      sec_tick_q     <= 1'b0;
      sec_rollover_q <= 1'b0;
      set_err_q      <= 1'b0;
    end else begin
      seconds_q      <= seconds_d;
      sec_tick_q     <= sec_tick_d;
      sec_rollover_q <= sec_rollover_d;
      set_err_q      <= set_err_d;
    end
  end

  assign seconds      = seconds_q;
  assign sec_tick     = sec_tick_q;
  assign sec_rollover = sec_rollover_q;
  assign set_err      = set_err_q;

endmodule
`default_nettype wire
